// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port round-robin arbiter and access formatter for the
// 32-bit data BRAM. Port 0 is the load/store unit, port 1 the loader/debug
// master. Byte addresses and access sizes become a word index, byte enables
// and lane-aligned store data. Responses (zero-extended load data or an
// error flag) appear exactly one cycle after a request is accepted.
module bram_arbiter #(
    parameter int DEPTH   = 32768,
    parameter bit RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic        req_we_0,
    input  logic [1:0]  req_size_0,
    input  logic [31:0] req_addr_0,
    input  logic [31:0] req_wdata_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic        req_we_1,
    input  logic [1:0]  req_size_1,
    input  logic [31:0] req_addr_1,
    input  logic [31:0] req_wdata_1,

    output logic        rsp_valid_0,
    output logic [31:0] rsp_rdata_0,
    output logic        rsp_err_0,

    output logic        rsp_valid_1,
    output logic [31:0] rsp_rdata_1,
    output logic        rsp_err_1,

    output logic [3:0]  mem_w_enable,
    output logic [31:0] mem_r_addr,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    // Everything the response cycle needs to know about the accepted request.
    typedef struct packed {
        logic       port;
        logic       we;
        size_e      size;
        logic [1:0] off;
        logic       err;
    } stage_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic        last_grant_q, last_grant_d;
    logic        stage_valid_q, stage_valid_d;
    stage_t      stage_q, stage_d;

    logic        grant_0, grant_1, accept;
    logic        sel_we;
    size_e       sel_size;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_off;
    logic [29:0] sel_word;
    logic        sel_err;
    logic [3:0]  be_base;
    logic [31:0] rsp_lane, rsp_data;

    // Round-robin grant: a lone requester wins, a tie goes to the port that
    // did not win last time; nothing is granted while reset is held.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (no inferred latch).
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!rst) begin
            if (req_valid_0 && req_valid_1) begin
                if (last_grant_q) grant_0 = 1'b1;
                else              grant_1 = 1'b1;
            end else if (req_valid_0) begin
                grant_0 = 1'b1;
            end else if (req_valid_1) begin
                grant_1 = 1'b1;
            end
        end
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign accept      = grant_0 | grant_1;

    // Select the granted request and decode address, alignment and range.
    always_comb begin
        sel_we    = grant_1 ? req_we_1    : req_we_0;
        sel_size  = size_e'(grant_1 ? req_size_1 : req_size_0);
        sel_addr  = grant_1 ? req_addr_1  : req_addr_0;
        sel_wdata = grant_1 ? req_wdata_1 : req_wdata_0;
        sel_off   = sel_addr[1:0];
        sel_word  = sel_addr[31:2];
        sel_err   = 1'b0;
        be_base   = 4'b0000;
        case (sel_size)
            SZ_BYTE: be_base = 4'b0001;
            SZ_HALF: begin
                be_base = 4'b0011;
                sel_err = sel_off[0];
            end
            SZ_WORD: begin
                be_base = 4'b1111;
                sel_err = (sel_off != 2'd0);
            end
            default: sel_err = 1'b1;
        endcase
        if ({2'b00, sel_word} >= DEPTH_W) sel_err = 1'b1;
    end

    // Drive the BRAM during the grant cycle; only error-free stores write.
    always_comb begin
        mem_r_addr   = 32'd0;
        mem_w_enable = 4'b0000;
        mem_w_data   = 32'd0;
        if (accept) begin
            mem_r_addr = {2'b00, sel_word};
            if (sel_we && !sel_err) begin
                mem_w_enable = be_base << sel_off;
                mem_w_data   = sel_wdata << {sel_off, 3'b000};
            end
        end
    end

    assign mem_w_addr = mem_r_addr;

    // Next-state for the round-robin pointer and the response stage.
    always_comb begin
        last_grant_d  = accept ? grant_1 : last_grant_q;
        stage_valid_d = accept;
        stage_d       = accept ? '{port: grant_1, we: sel_we, size: sel_size,
                                   off: sel_off, err: sel_err}
                               : stage_q;
    end

    // Control state: reset restores the pointer and drops any in-flight response.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            last_grant_q  <= RR_INIT;
            stage_valid_q <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    // Stage payload: meaningful only while stage_valid_q is set.
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately not reset; the valid bit alone
        // qualifies it, which keeps reset fan-out off the datapath.
        stage_q <= stage_d;
    end

    // Extract the addressed lane from the BRAM word and zero-extend it.
    always_comb begin
        rsp_lane = mem_r_data >> {stage_q.off, 3'b000};
        case (stage_q.size)
            SZ_BYTE: rsp_lane = {24'd0, rsp_lane[7:0]};
            SZ_HALF: rsp_lane = {16'd0, rsp_lane[15:0]};
            default: rsp_lane = rsp_lane;
        endcase
        rsp_data = (stage_q.we || stage_q.err) ? 32'd0 : rsp_lane;
    end

    assign rsp_valid_0 = stage_valid_q && !rst && !stage_q.port;
    assign rsp_valid_1 = stage_valid_q && !rst &&  stage_q.port;
    assign rsp_rdata_0 = rsp_valid_0 ? rsp_data : 32'd0;
    assign rsp_rdata_1 = rsp_valid_1 ? rsp_data : 32'd0;
    assign rsp_err_0   = rsp_valid_0 && stage_q.err;
    assign rsp_err_1   = rsp_valid_1 && stage_q.err;

endmodule
